// File: rtl/square_root.sv
// Sequential geometric-mean unit: out = floor(sqrt(In1 * In2)) for 5-bit operands.
// Restoring digit-by-digit square root on the 10-bit product, one result bit per cycle.
module square_root (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [4:0] In1,
  input  logic [4:0] In2,
  output logic [4:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] rad_q, rad_d;
  logic [4:0] root_q, root_d;
  logic [6:0] rem_q, rem_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] out_q, out_d;

  logic [8:0] r2;
  logic [6:0] trial;
  logic [6:0] diff;

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    // The remainder never exceeds 2*root, so the 7-bit difference cannot wrap
    // whenever r2 >= trial; r2's upper bits only matter for the comparison.
    r2    = {rem_q, rad_q[9:8]};
    trial = {root_q, 2'b01};
    diff  = r2[6:0] - trial;

    case (state_q)
      IDLE: begin
        if (start) begin
          rad_d   = {5'b00000, In1} * {5'b00000, In2};
          root_d  = 5'd0;
          rem_d   = 7'd0;
          cnt_d   = 3'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (r2 >= {2'b00, trial}) begin
          rem_d  = diff;
          root_d = {root_q[3:0], 1'b1};
        end else begin
          rem_d  = r2[6:0];
          root_d = {root_q[3:0], 1'b0};
        end
        rad_d = {rad_q[7:0], 2'b00};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_d   = root_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      rad_q   <= 10'd0;
      root_q  <= 5'd0;
      rem_q   <= 7'd0;
      cnt_q   <= 3'd0;
      out_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_square_root.sv
// Self-checking bench for square_root: directed corners plus randomized operands
// compared against an integer square-root reference model.
module tb_square_root;

  logic       clk;
  logic       clear;
  logic       start;
  logic [4:0] In1;
  logic [4:0] In2;
  logic [4:0] out;

  int checks;
  int errors;
  int last_out;

  square_root dut (
    .clk   (clk),
    .clear (clear),
    .start (start),
    .In1   (In1),
    .In2   (In2),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Largest r with r*r <= v, found by plain search.
  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Starts one computation from IDLE (called #1 after a rising edge) and scrambles
  // the operands right after capture; returns out just before and just after E6.
  task automatic compute(input logic [4:0] a, input logic [4:0] b,
                         output logic [4:0] before_v, output logic [4:0] after_v);
    In1   = a;
    In2   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    In1   = 5'($urandom_range(31, 0));
    In2   = 5'($urandom_range(31, 0));
    repeat (5) @(posedge clk);
    #1 before_v = out;
    @(posedge clk);
    #1 after_v = out;
  endtask

  task automatic test_reset;
    clear = 1'b1;
    start = 1'b0;
    In1   = 5'd0;
    In2   = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_out: got %0d expected 0", out);
    end
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      In1 = 5'($urandom_range(31, 0));
      In2 = 5'($urandom_range(31, 0));
      @(posedge clk); #1;
      checks++;
      if (out !== 5'd0) begin
        errors++;
        $display("[TB] FAIL idle_hold_%0d: got %0d expected 0", i, out);
      end
    end
    last_out = 0;
  endtask

  task automatic test_captured_operands;
    logic [4:0] b_v, a_v;
    compute(5'd29, 5'd28, b_v, a_v);
    checks++;
    if (int'(b_v) !== last_out) begin
      errors++;
      $display("[TB] FAIL capture_hold: got %0d expected %0d", b_v, last_out);
    end
    checks++;
    if (int'(a_v) !== 28) begin
      errors++;
      $display("[TB] FAIL capture_29x28: got %0d expected 28", a_v);
    end
    last_out = 28;
  endtask

  task automatic test_values;
    logic [4:0] b_v, a_v;
    logic [4:0] ta [6];
    logic [4:0] tb [6];
    int         te [6];
    ta = '{5'd6, 5'd4, 5'd31, 5'd0,  5'd1, 5'd31};
    tb = '{5'd8, 5'd9, 5'd31, 5'd17, 5'd1, 5'd1};
    te = '{6,    6,    31,    0,     1,    5};
    for (int i = 0; i < 6; i++) begin
      compute(ta[i], tb[i], b_v, a_v);
      checks++;
      if (int'(b_v) !== last_out) begin
        errors++;
        $display("[TB] FAIL value_hold_%0d: got %0d expected %0d", i, b_v, last_out);
      end
      checks++;
      if (int'(a_v) !== te[i]) begin
        errors++;
        $display("[TB] FAIL value_%0dx%0d: got %0d expected %0d", ta[i], tb[i], a_v, te[i]);
      end
      last_out = te[i];
    end
  endtask

  task automatic test_random;
    logic [4:0] b_v, a_v, ra, rb;
    int         exp_v;
    for (int i = 0; i < 20; i++) begin
      ra    = 5'($urandom_range(31, 0));
      rb    = 5'($urandom_range(31, 0));
      exp_v = isqrt(int'(ra) * int'(rb));
      compute(ra, rb, b_v, a_v);
      checks++;
      if (int'(a_v) !== exp_v) begin
        errors++;
        $display("[TB] FAIL random_%0dx%0d: got %0d expected %0d", ra, rb, a_v, exp_v);
      end
      last_out = exp_v;
    end
  endtask

  // start held high with operands changing every cycle: captures only every 7th edge.
  task automatic test_back_to_back;
    logic [4:0] a_at [36];
    logic [4:0] b_at [36];
    int         exp_v;
    a_at[0] = 5'($urandom_range(31, 0));
    b_at[0] = 5'($urandom_range(31, 0));
    In1   = a_at[0];
    In2   = b_at[0];
    start = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); #1;
      if (k % 7 == 6) begin
        exp_v = isqrt(int'(a_at[k - 6]) * int'(b_at[k - 6]));
        checks++;
        if (int'(out) !== exp_v) begin
          errors++;
          $display("[TB] FAIL b2b_edge%0d: got %0d expected %0d", k, out, exp_v);
        end
        last_out = exp_v;
      end else if (k % 7 == 3) begin
        checks++;
        if (int'(out) !== last_out) begin
          errors++;
          $display("[TB] FAIL b2b_hold_edge%0d: got %0d expected %0d", k, out, last_out);
        end
      end
      a_at[k + 1] = 5'($urandom_range(31, 0));
      b_at[k + 1] = 5'($urandom_range(31, 0));
      In1 = a_at[k + 1];
      In2 = b_at[k + 1];
    end
    start = 1'b0;
  endtask

  task automatic test_clear_mid_calc;
    logic [4:0] b_v, a_v;
    In1   = 5'd31;
    In2   = 5'd31;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (out !== 5'd0) begin
      errors++;
      $display("[TB] FAIL clear_mid: got %0d expected 0", out);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out !== 5'd0) begin
      errors++;
      $display("[TB] FAIL clear_abort_hold: got %0d expected 0", out);
    end
    last_out = 0;
    compute(5'd4, 5'd9, b_v, a_v);
    checks++;
    if (int'(a_v) !== 6) begin
      errors++;
      $display("[TB] FAIL after_clear_4x9: got %0d expected 6", a_v);
    end
    last_out = 6;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_captured_operands();
    test_values();
    test_random();
    test_back_to_back();
    test_clear_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
